// File: rtl/seq_shifter_if.sv
// ---------------------------------------------------------------------------
// seq_shifter_if
//   Request/response bundle for the iterative shifter.
//
//   Handshake rule for both channels: a transfer happens on a rising clock
//   edge where valid && ready are both high. The producer holds valid and
//   its payload stable until that edge. The consumer may raise or lower
//   ready at any time.
//
//   Signals
//     in_valid    request valid (requester -> shifter)
//     in_ready    shifter can accept a request
//     a           operand, WIDTH bits
//     shamt       shift amount, $clog2(WIDTH) bits
//     shift_type  00 SLL, 01 SRL, 10 SRA, 11 rotate-right / pass-through
//     out_valid   result valid (shifter -> requester)
//     out_ready   requester accepts the result
//     r           result, WIDTH bits
//
//   Modports: master = requester side, slave = shifter side.
// ---------------------------------------------------------------------------
interface seq_shifter_if #(
   parameter int WIDTH = 32
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [SHW-1:0]   shamt;
   logic [1:0]       shift_type;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] r;

   modport master (
      output in_valid, a, shamt, shift_type, out_ready,
      input  in_ready, out_valid, r
   );

   modport slave (
      input  in_valid, a, shamt, shift_type, out_ready,
      output in_ready, out_valid, r
   );
endinterface

// File: rtl/seq_shifter.sv
// ---------------------------------------------------------------------------
// seq_shifter
//   Multi-cycle iterative shift unit. Shifts up to STEP bits per clock so a
//   shift by shamt takes 1 + ceil(shamt/STEP) cycles from accept to result.
//   One operation in flight at a time; requests are only taken in IDLE.
//
//   Parameters
//     WIDTH  operand/result width (shamt is $clog2(WIDTH) bits)
//     STEP   max bits shifted per cycle, power of two, 1..WIDTH/2
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     bus        seq_shifter_if.slave request/response channels
//     busy       high while an operation is in SHIFT or DONE
//     state_dbg  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
//   Build option
//     SHIFTER_ROTATE_EN  when defined, shift_type 11 rotates right by shamt.
//                        When undefined, shift_type 11 is a 1-cycle
//                        pass-through (r = a) and no rotate path exists.
// ---------------------------------------------------------------------------
module seq_shifter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic           clk,
   input  logic           rst,
   seq_shifter_if.slave   bus,
   output logic           busy,
   output logic [1:0]     state_dbg
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;
   logic [1:0]       op;
   logic             sign;

   logic [SHW-1:0]   k;
   logic [WIDTH-1:0] acc_sh;
   logic [WIDTH-1:0] fill;
   logic             accept;
   logic             skip_shift;

   assign accept = bus.in_valid && (state == S_IDLE);

   // Requests that need no shifting cycles go straight to DONE.
`ifdef SHIFTER_ROTATE_EN
   assign skip_shift = (bus.shamt == '0);
`else
   assign skip_shift = (bus.shamt == '0) || (bus.shift_type == 2'b11);
`endif

   // -------------------------------------------------------------------------
   // One shift step: k never exceeds cnt, so cnt cannot underflow.
   // -------------------------------------------------------------------------
   always_comb begin
      k      = (cnt < STEP_W) ? cnt : STEP_W;
      fill   = (op == OP_SRA) ? {WIDTH{sign}} : '0;
      acc_sh = acc;
      case (op)
         OP_SLL: acc_sh = acc << k;
         OP_SRL,
         OP_SRA: acc_sh = WIDTH'({fill, acc} >> k);
         default: begin
`ifdef SHIFTER_ROTATE_EN
            // Rotate right: low bits shifted out re-enter at the top.
            acc_sh = WIDTH'({acc, acc} >> k);
`else
            acc_sh = acc;
`endif
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next-state and handshake outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_n       = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;
      case (state)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_n = skip_shift ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (cnt == k) begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            busy          = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: operands are latched on accept so the requester may change
   // its inputs afterwards. acc also holds the result through DONE.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         cnt  <= '0;
         op   <= '0;
         sign <= 1'b0;
      end else if (accept) begin
         acc  <= bus.a;
         cnt  <= bus.shamt;
         op   <= bus.shift_type;
         sign <= bus.a[WIDTH-1];
      end else if (state == S_SHIFT) begin
         acc <= acc_sh;
         cnt <= cnt - k;
      end
   end

   assign bus.r     = acc;
   assign state_dbg = state;

endmodule

// File: tb/tb_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_seq_shifter
//   Directed bench for seq_shifter (WIDTH=32, STEP=1). Expected results are
//   hand-computed constants; back-to-back results go through exp_q.
// ---------------------------------------------------------------------------
module tb_seq_shifter;
   localparam int WIDTH = 32;
   localparam int STEP  = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_shifter_if #(.WIDTH(WIDTH)) bus ();
   logic       busy;
   logic [1:0] state_dbg;

   seq_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] exp_q[$];

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, scramble the inputs right after accept, wait for
   // the result, then consume it. lat counts edges from accept to out_valid
   // (1 means out_valid right after the accept edge).
   task automatic run_op(input logic [31:0] a, input logic [4:0] shamt,
                         input logic [1:0] typ, output logic [31:0] res,
                         output int lat, output bit ok);
      int g;
      g = 0;
      while (!bus.in_ready && g < 200) begin
         step();
         g++;
      end
      bus.a          = a;
      bus.shamt      = shamt;
      bus.shift_type = typ;
      bus.in_valid   = 1'b1;
      step();
      bus.in_valid   = 1'b0;
      bus.a          = $urandom;
      bus.shamt      = 5'($urandom_range(0, 31));
      bus.shift_type = 2'($urandom_range(0, 3));
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         step();
         lat++;
      end
      res = bus.r;
      ok  = bus.out_valid;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b0;
      bus.a          = '0;
      bus.shamt      = '0;
      bus.shift_type = '0;
      #22;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.r !== 32'h0) begin errors++; $display("FAIL reset_r got %h exp 00000000", bus.r); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_sll_full();
      logic [31:0] res; int lat; bit ok;
      run_op(32'h0000_0001, 5'd31, 2'b00, res, lat, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sll31_timeout got %b exp 1", ok); end
      checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL sll31_r got %h exp 80000000", res); end
      checks++; if (lat != 32) begin errors++; $display("FAIL sll31_latency got %0d exp 32", lat); end
   endtask

   task automatic test_sra_srl();
      logic [31:0] res; int lat; bit ok;
      run_op(32'h8000_00F0, 5'd4, 2'b10, res, lat, ok);
      checks++; if (res !== 32'hF800_000F) begin errors++; $display("FAIL sra4_r got %h exp f800000f", res); end
      checks++; if (lat != 5) begin errors++; $display("FAIL sra4_latency got %0d exp 5", lat); end
      run_op(32'h8000_00F0, 5'd4, 2'b01, res, lat, ok);
      checks++; if (res !== 32'h0800_000F) begin errors++; $display("FAIL srl4_r got %h exp 0800000f", res); end
      checks++; if (lat != 5) begin errors++; $display("FAIL srl4_latency got %0d exp 5", lat); end
   endtask

   task automatic test_zero_shamt();
      logic [31:0] res; int lat; bit ok;
      for (int t = 0; t < 4; t++) begin
         run_op(32'h1234_5678, 5'd0, 2'(t), res, lat, ok);
         checks++; if (res !== 32'h1234_5678) begin errors++; $display("FAIL zero_shamt_r type %0d got %h exp 12345678", t, res); end
         checks++; if (lat != 1) begin errors++; $display("FAIL zero_shamt_latency type %0d got %0d exp 1", t, lat); end
      end
   endtask

   task automatic test_type11();
      logic [31:0] res; int lat; bit ok;
      logic [31:0] exp_r; int exp_lat;
`ifdef SHIFTER_ROTATE_EN
      exp_r = 32'hF000_0000; exp_lat = 5;
`else
      exp_r = 32'h0000_000F; exp_lat = 1;
`endif
      run_op(32'h0000_000F, 5'd4, 2'b11, res, lat, ok);
      checks++; if (res !== exp_r) begin errors++; $display("FAIL type11_r got %h exp %h", res, exp_r); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL type11_latency got %0d exp %0d", lat, exp_lat); end
   endtask

   task automatic test_backpressure();
      int g;
      bus.a = 32'h0000_00F0; bus.shamt = 5'd4; bus.shift_type = 2'b01;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_busy_after_accept got in_ready=%b busy=%b exp 0/1", bus.in_ready, busy); end
      g = 0;
      while (!bus.out_valid && g < 200) begin step(); g++; end
      checks++; if (bus.r !== 32'h0000_000F) begin errors++; $display("FAIL bp_r got %h exp 0000000f", bus.r); end
      // A second request during DONE must be ignored.
      bus.a = 32'hFFFF_FFFF; bus.shamt = 5'd3; bus.shift_type = 2'b00;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b exp 1", i, bus.out_valid); end
         checks++; if (bus.r !== 32'h0000_000F) begin errors++; $display("FAIL bp_hold_r cycle %0d got %h exp 0000000f", i, bus.r); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cycle %0d got %b exp 0", i, bus.in_ready); end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      checks++; if (state_dbg !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got state=%0d in_ready=%b out_valid=%b exp 0/1/0", state_dbg, bus.in_ready, bus.out_valid); end
      repeat (3) step();
      checks++; if (state_dbg !== 2'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_queue got state=%0d out_valid=%b exp 0/0", state_dbg, bus.out_valid); end
   endtask

   task automatic test_reset_mid_shift();
      logic [31:0] res; int lat; bit ok;
      bus.a = 32'h0000_0001; bus.shamt = 5'd31; bus.shift_type = 2'b00;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      repeat (5) step();
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL midrst_pre_state got %0d exp 1", state_dbg); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.r !== 32'h0) begin errors++; $display("FAIL midrst_r got %h exp 00000000", bus.r); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
      rst = 1'b0;
      step();
      run_op(32'h8000_00F0, 5'd4, 2'b10, res, lat, ok);
      checks++; if (res !== 32'hF800_000F) begin errors++; $display("FAIL midrst_next_r got %h exp f800000f", res); end
   endtask

   task automatic test_back_to_back();
      localparam int N = 8;
      logic [31:0] va [N] = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h7000_0000,
                              32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0003, 32'hDEAD_BEEF};
      logic [4:0]  vs [N] = '{5'd8, 5'd8, 5'd8, 5'd31, 5'd31, 5'd31, 5'd1, 5'd0};
      logic [1:0]  vt [N] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10};
      logic [31:0] ve [N] = '{32'hF0F0_F000, 32'h00F0_F0F0, 32'hFFF0_F0F0, 32'h0000_0000,
                              32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0006, 32'hDEAD_BEEF};
      int acc_cyc [N];
      int idx, done_cnt, cyc;
      bit accept_now, out_now;
      logic [WIDTH-1:0] exp_r;
      idx = 0; done_cnt = 0; cyc = 0;
      bus.out_ready  = 1'b1;
      bus.a          = va[0];
      bus.shamt      = vs[0];
      bus.shift_type = vt[0];
      bus.in_valid   = 1'b1;
      while (done_cnt < N && cyc < 2000) begin
         accept_now = bus.in_valid && bus.in_ready;
         out_now    = bus.out_valid && bus.out_ready;
         if (out_now) begin
            exp_r = exp_q.pop_front();
            checks++; if (bus.r !== exp_r) begin errors++; $display("FAIL b2b_r op %0d got %h exp %h", done_cnt, bus.r, exp_r); end
            done_cnt++;
         end
         step();
         cyc++;
         if (accept_now) begin
            exp_q.push_back(ve[idx]);
            acc_cyc[idx] = cyc;
            idx++;
            if (idx < N) begin
               bus.a = va[idx]; bus.shamt = vs[idx]; bus.shift_type = vt[idx];
            end else begin
               bus.in_valid = 1'b0;
            end
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checks++; if (done_cnt != N) begin errors++; $display("FAIL b2b_completed got %0d exp %0d", done_cnt, N); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue_empty got %0d exp 0", exp_q.size()); end
      // STEP=1: latency is 1+shamt, throughput is latency+1.
      if (done_cnt == N) begin
         for (int i = 0; i < N - 1; i++) begin
            checks++;
            if (acc_cyc[i+1] - acc_cyc[i] != int'(vs[i]) + 2) begin
               errors++;
               $display("FAIL b2b_spacing op %0d got %0d exp %0d", i, acc_cyc[i+1] - acc_cyc[i], int'(vs[i]) + 2);
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_sll_full();
      test_sra_srl();
      test_zero_shamt();
      test_type11();
      test_backpressure();
      test_reset_mid_shift();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
